// File: rtl/register_writeback_bank.sv
// register_writeback_bank: buffers tagged results in a small FIFO and commits one per
// cycle into an 8-entry register bank, with a per-register busy scoreboard.
module register_writeback_bank #(
    parameter int unsigned DATA_WIDTH = 16,
    parameter int unsigned FIFO_DEPTH = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  wr_valid,
    output logic                  wr_ready,
    input  logic [2:0]            wr_addr,
    input  logic [DATA_WIDTH-1:0] wr_data,
    input  logic                  reserve_valid,
    input  logic [2:0]            reserve_addr,
    output logic [7:0]            busy,
    output logic                  done_valid,
    output logic [2:0]            done_addr,
    output logic [DATA_WIDTH-1:0] r0,
    output logic [DATA_WIDTH-1:0] r1,
    output logic [DATA_WIDTH-1:0] r2,
    output logic [DATA_WIDTH-1:0] r3,
    output logic [DATA_WIDTH-1:0] r4,
    output logic [DATA_WIDTH-1:0] r5,
    output logic [DATA_WIDTH-1:0] r6,
    output logic [DATA_WIDTH-1:0] r7
);

    // Only depths 2 and 4 are supported, so a 1- or 2-bit pointer suffices.
    localparam int unsigned PW = (FIFO_DEPTH > 2) ? 2 : 1;
    localparam int unsigned CW = PW + 1;
    localparam logic [CW-1:0] FULL_CNT = CW'(FIFO_DEPTH);
    localparam logic [PW-1:0] LAST_PTR = PW'(FIFO_DEPTH - 1);

    typedef enum logic [0:0] {StIdle, StDrain} state_t;

    state_t                state_q;
    logic [CW-1:0]         count_q, count_d;
    logic [PW-1:0]         wr_ptr_q, rd_ptr_q;
    logic [2:0]            fifo_addr [FIFO_DEPTH];
    logic [DATA_WIDTH-1:0] fifo_data [FIFO_DEPTH];
    logic [DATA_WIDTH-1:0] regs [8];
    logic [7:0]            busy_d;
    logic                  push, pop;

    assign wr_ready = !rst && (count_q < FULL_CNT);

    // Handshake decode, next count and next scoreboard value.
    always_comb begin
        push    = wr_valid && wr_ready;
        pop     = (state_q == StDrain);
        count_d = count_q;
        if (push && !pop) begin
            count_d = count_q + CW'(1);
        end else if (!push && pop) begin
            count_d = count_q - CW'(1);
        end
        busy_d = busy;
        if (pop) begin
            busy_d[fifo_addr[rd_ptr_q]] = 1'b0;
        end
        // A newer producer reserving the same register overrides the commit clear.
        if (reserve_valid) begin
            busy_d[reserve_addr] = 1'b1;
        end
    end

    // Control FSM: occupancy, pointers, commit pulse and scoreboard.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= StIdle;
            count_q    <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            done_valid <= 1'b0;
            done_addr  <= 3'd0;
            busy       <= 8'h00;
        end else begin
            count_q    <= count_d;
            state_q    <= (count_d != '0) ? StDrain : StIdle;
            busy       <= busy_d;
            done_valid <= pop;
            if (pop) begin
                done_addr <= fifo_addr[rd_ptr_q];
                rd_ptr_q  <= (rd_ptr_q == LAST_PTR) ? '0 : rd_ptr_q + PW'(1);
            end
            if (push) begin
                wr_ptr_q <= (wr_ptr_q == LAST_PTR) ? '0 : wr_ptr_q + PW'(1);
            end
        end
    end

    // Write-buffer storage; push is already blocked during reset via wr_ready.
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_addr[wr_ptr_q] <= wr_addr;
            fifo_data[wr_ptr_q] <= wr_data;
        end
    end

    // Register bank: commit the FIFO head.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 8; i++) begin
                regs[i] <= '0;
            end
        end else if (pop) begin
            regs[fifo_addr[rd_ptr_q]] <= fifo_data[rd_ptr_q];
        end
    end

    assign r0 = regs[0];
    assign r1 = regs[1];
    assign r2 = regs[2];
    assign r3 = regs[3];
    assign r4 = regs[4];
    assign r5 = regs[5];
    assign r6 = regs[6];
    assign r7 = regs[7];

endmodule

// File: doc/register_writeback_bank.md
Name: register_writeback_bank

Overview:
Write-side counterpart of the 8:1 operand multiplexer. It accepts ALU/load results tagged with a 3-bit destination, buffers them in a 2-entry FIFO, and commits one result per cycle into an 8 x 16-bit register bank. The bank outputs r0..r7 feed the operand multiplexer inputs in0..in7 directly. A per-register busy scoreboard lets the control FSM stall operand reads of registers with an outstanding write.

Parameters:
DATA_WIDTH, 16, width of each register and of wr_data.
FIFO_DEPTH, 2, number of write-buffer entries; supported values are 2 and 4 only.

Ports:
Clock  input  1  system clock; all state updates on the rising edge.
Reset  input  1  synchronous, active-high reset.
wr_valid  input  1  a write request is presented.
wr_ready  output  1  the bank can accept a request this cycle.
wr_addr  input  3  destination register index.
wr_data  input  DATA_WIDTH  result value.
reserve_valid  input  1  marks a register as having a pending write.
reserve_addr  input  3  register to reserve.
busy  output  8  busy[i] = 1 while register i has a reserved or in-flight write.
done_valid  output  1  one-cycle pulse when a write commits.
done_addr  output  3  index of the committed register, valid while done_valid is high.
r0..r7  output  DATA_WIDTH each  current register contents.

Behaviour:
- Reset, sampled on a rising edge:
  - r0..r7 = 0; busy = 0; done_valid = 0; done_addr = 0.
  - FIFO count = 0; read and write pointers = 0.
  - Reset overrides every concurrent request, including any handshake in the reset cycle. Mid-operation reset discards buffered writes without committing them.
- wr_ready = !Reset && (count < FIFO_DEPTH). It is combinational from registered state and never depends on wr_valid.
- Accept: wr_valid && wr_ready at an edge pushes {wr_addr, wr_data} at the write pointer. The pointer wraps modulo FIFO_DEPTH.
  - wr_valid with wr_ready low is ignored. The requester must hold the request.
- Commit: at each edge with count > 0 (sampled before the edge), the head entry is written to r[addr]. The read pointer advances with wrap, and done_valid/done_addr are registered for exactly one cycle.
- Latency and throughput:
  - Request accepted at edge N commits at edge N+1. The new value is visible on rN and done_valid is high from edge N+1.
  - Sustained rate is 1 write/cycle.
  - Push and pop in the same edge leave count unchanged.
  - A full FIFO drops wr_ready for at least one cycle, until the next commit frees an entry.
- Ordering: commits occur strictly in acceptance order. Two queued writes to the same register commit in order, and the last one wins.
- r0 is an ordinary writable register and is not hardwired to zero.
- Scoreboard, at each edge:
  - reserve_valid sets busy[reserve_addr].
  - A commit clears busy[done address].
  - Reserve and commit of the same index in one edge: the reserve wins and busy stays 1, because a newer producer owns the register.
  - Reserve and commit of different indices apply independently.
  - Reserving an already-busy register is legal and leaves it busy.
- Commit of a register that was never reserved is legal; busy stays 0.
- done_valid is 0 on every edge with count = 0.
- Internal FSM has two states:
  - IDLE (count = 0).
  - DRAIN (count > 0), with transitions driven by the next count.
  - done_valid is high exactly on the cycles following edges that were in DRAIN.
- All outputs are registered except wr_ready.

Test Plan:
- Reset is held 2 cycles after writes were queued -> r0..r7 = 0x0000, busy = 0x00, done_valid = 0, wr_ready = 0 during reset and 1 on the first cycle after.
- Single write: wr_addr = 5, wr_data = 0xBEEF accepted at edge N -> r5 = 0xBEEF and done_valid = 1 with done_addr = 5 after edge N+1; done_valid = 0 after edge N+2.
- Back-to-back writes r1 = 0x0001, r2 = 0x0002, r1 = 0x0003 on consecutive cycles -> wr_ready stays 1, commits occur in order on three consecutive edges, final r1 = 0x0003 and r2 = 0x0002.
- Backpressure, FIFO_DEPTH = 2: writes arrive every cycle -> wr_ready never drops because a commit occurs each edge.
  - Force fill by testing FIFO_DEPTH = 4 with 5 writes in flight -> no write is lost and all 5 appear on done_addr in order.
- Scoreboard: reserve r3 at edge N -> busy = 0x08 after N. The write to r3 commits together with a new reserve of r3 -> busy[3] stays 1. A later commit with no reserve -> busy = 0x00.
- Mid-operation reset with 2 entries queued -> neither register is updated, done_valid never pulses for those entries, count = 0.
